// File: rtl/hbconsole_pkg.sv
// hbconsole_pkg: shared constants and enums for the hexbus/console byte mux.
//   HB_NEWLINE  - hexbus end-of-packet character
//   CON_TAG_BIT - bit of the link byte that marks a console character
//   state_t     - TX arbiter state (IDLE, LOCK)
//   sel_t       - TX source select (SEL_HB, SEL_CON)
package hbconsole_pkg;

    localparam logic [6:0] HB_NEWLINE  = 7'h0a;
    localparam int         CON_TAG_BIT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef enum logic {
        SEL_HB  = 1'b0,
        SEL_CON = 1'b1
    } sel_t;

endpackage

// File: rtl/hbconsole_mux.sv
// hbconsole_mux: shares one UART byte link between the hexbus debug protocol
// and a 7-bit console character stream.
//
// state | meaning
// IDLE  | no hexbus packet open; hexbus and console arbitrated round-robin
// LOCK  | hexbus packet open; only hexbus may send until newline or timeout
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_rx_stb, i_rx_byte             byte from UART receiver
//   o_hb_rx_stb, o_hb_rx_data       bit7=0 bytes to the hexbus decoder
//   o_con_rx_stb, o_con_rx_data     bit7=1 bytes to the console
//   i_hb_tx_stb, i_hb_tx_data       hexbus encoder character, o_hb_tx_busy back
//   i_con_tx_stb, i_con_tx_data     console character, o_con_tx_busy back
//   o_tx_stb, o_tx_byte, i_tx_busy  byte to UART transmitter
module hbconsole_mux
    import hbconsole_pkg::*;
#(
    parameter int LGTIMEOUT = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_stb,
    input  logic [7:0] i_rx_byte,
    output logic       o_hb_rx_stb,
    output logic [6:0] o_hb_rx_data,
    output logic       o_con_rx_stb,
    output logic [6:0] o_con_rx_data,
    input  logic       i_hb_tx_stb,
    input  logic [6:0] i_hb_tx_data,
    output logic       o_hb_tx_busy,
    input  logic       i_con_tx_stb,
    input  logic [6:0] i_con_tx_data,
    output logic       o_con_tx_busy,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_busy
);

    localparam logic [LGTIMEOUT-1:0] TIMEOUT_MAX  = '1;
    localparam logic [LGTIMEOUT-1:0] TIMEOUT_LAST = TIMEOUT_MAX - 1'b1;

    state_t               state, state_next;
    sel_t                 rr_ptr, rr_ptr_next;
    logic [LGTIMEOUT-1:0] idle_cnt, idle_cnt_next;
    logic                 load_en;
    logic                 hb_grant, con_grant;
    logic                 hb_accept, con_accept;

    // RX demux
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hb_rx_stb   <= 1'b0;
            o_con_rx_stb  <= 1'b0;
            o_hb_rx_data  <= '0;
            o_con_rx_data <= '0;
        end else begin
            o_con_rx_stb <= i_rx_stb &&  i_rx_byte[CON_TAG_BIT];
            o_hb_rx_stb  <= i_rx_stb && !i_rx_byte[CON_TAG_BIT];
            if (i_rx_stb) begin
                o_hb_rx_data  <= i_rx_byte[6:0];
                o_con_rx_data <= i_rx_byte[6:0];
            end
        end
    end

    assign load_en = !o_tx_stb || !i_tx_busy;

    // Each grant is the "sel == source" term written using only the other
    // source's strobe, so neither busy output depends on its own strobe.
    // With no strobes at all both grants are open, which is harmless.
    assign hb_grant  = (state == LOCK) || !i_con_tx_stb || (rr_ptr == SEL_HB);
    assign con_grant = (state == IDLE) && (!i_hb_tx_stb || (rr_ptr == SEL_CON));

    assign o_hb_tx_busy  = !(load_en && hb_grant);
    assign o_con_tx_busy = !(load_en && con_grant);

    assign hb_accept  = i_hb_tx_stb  && !o_hb_tx_busy;
    assign con_accept = i_con_tx_stb && !o_con_tx_busy;

    // TX output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tx_stb  <= 1'b0;
            o_tx_byte <= '0;
        end else if (load_en) begin
            if (hb_accept) begin
                o_tx_stb  <= 1'b1;
                o_tx_byte <= {1'b0, i_hb_tx_data};
            end else if (con_accept) begin
                o_tx_stb  <= 1'b1;
                o_tx_byte <= {1'b1, i_con_tx_data};
            end else begin
                o_tx_stb  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            rr_ptr   <= SEL_HB;
            idle_cnt <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            idle_cnt <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        idle_cnt_next = idle_cnt;
        case (state)
            IDLE: begin
                idle_cnt_next = '0;
                if (hb_accept) begin
                    rr_ptr_next = SEL_CON;
                    if (i_hb_tx_data != HB_NEWLINE)
                        state_next = LOCK;
                end else if (con_accept) begin
                    rr_ptr_next = SEL_HB;
                end
            end
            LOCK: begin
                if (hb_accept) begin
                    idle_cnt_next = '0;
                    if (i_hb_tx_data == HB_NEWLINE) begin
                        state_next  = IDLE;
                        rr_ptr_next = SEL_CON;
                    end
                end else if (idle_cnt == TIMEOUT_LAST) begin
                    // Counter is about to reach its maximum: release the lock
                    // so a stalled hexbus encoder cannot starve the console.
                    state_next    = IDLE;
                    rr_ptr_next   = SEL_CON;
                    idle_cnt_next = '0;
                end else if (idle_cnt != TIMEOUT_MAX) begin
                    idle_cnt_next = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                idle_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hbconsole_mux.sv
// tb_hbconsole_mux: directed and randomized bench for hbconsole_mux, with a
// cycle-level reference model of the link rules and character queues per source.
module tb_hbconsole_mux;

    localparam int LGT = 4;
    localparam int TMO = (1 << LGT) - 1;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx_stb;
    logic [7:0] i_rx_byte;
    logic       o_hb_rx_stb;
    logic [6:0] o_hb_rx_data;
    logic       o_con_rx_stb;
    logic [6:0] o_con_rx_data;
    logic       i_hb_tx_stb;
    logic [6:0] i_hb_tx_data;
    logic       o_hb_tx_busy;
    logic       i_con_tx_stb;
    logic [6:0] i_con_tx_data;
    logic       o_con_tx_busy;
    logic       o_tx_stb;
    logic [7:0] o_tx_byte;
    logic       i_tx_busy;

    hbconsole_mux #(.LGTIMEOUT(LGT)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_rx_stb      (i_rx_stb),
        .i_rx_byte     (i_rx_byte),
        .o_hb_rx_stb   (o_hb_rx_stb),
        .o_hb_rx_data  (o_hb_rx_data),
        .o_con_rx_stb  (o_con_rx_stb),
        .o_con_rx_data (o_con_rx_data),
        .i_hb_tx_stb   (i_hb_tx_stb),
        .i_hb_tx_data  (i_hb_tx_data),
        .o_hb_tx_busy  (o_hb_tx_busy),
        .i_con_tx_stb  (i_con_tx_stb),
        .i_con_tx_data (i_con_tx_data),
        .o_con_tx_busy (o_con_tx_busy),
        .o_tx_stb      (o_tx_stb),
        .o_tx_byte     (o_tx_byte),
        .i_tx_busy     (i_tx_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] hb_q[$];
    logic [6:0] con_q[$];
    logic [7:0] sent_q[$];

    // reference model state
    bit         m_lock    = 0;
    int         m_idle    = 0;
    bit         m_ptr_con = 0;
    bit         m_tx_stb  = 0;
    logic [7:0] m_tx_byte = '0;
    bit         m_hb_rx   = 0;
    bit         m_con_rx  = 0;
    logic [6:0] m_rx_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit         can_load, hb_turn, con_turn, e_hb_busy, e_con_busy;
        bit         hb_acc, con_acc, pre_stb, pre_busy;
        logic [7:0] pre_byte;
        logic [6:0] hb_d, con_d;

        i_hb_tx_stb   = (hb_q.size() != 0);
        i_hb_tx_data  = (hb_q.size() != 0) ? hb_q[0] : 7'h00;
        i_con_tx_stb  = (con_q.size() != 0);
        i_con_tx_data = (con_q.size() != 0) ? con_q[0] : 7'h00;
        hb_d  = i_hb_tx_data;
        con_d = i_con_tx_data;
        n_vec++;
        #1;
        // A new byte may enter the output register when it is empty or leaving.
        // Inside a packet only hexbus may send; otherwise on contention the
        // round-robin pointer picks, and an uncontested source always may.
        can_load   = !m_tx_stb || !i_tx_busy;
        hb_turn    = m_lock ? 1'b1 : (i_con_tx_stb ? !m_ptr_con : 1'b1);
        con_turn   = m_lock ? 1'b0 : (i_hb_tx_stb ? m_ptr_con : 1'b1);
        e_hb_busy  = !(can_load && hb_turn);
        e_con_busy = !(can_load && con_turn);
        chk("hb_tx_busy",  32'(o_hb_tx_busy),  32'(e_hb_busy));
        chk("con_tx_busy", 32'(o_con_tx_busy), 32'(e_con_busy));
        hb_acc   = i_hb_tx_stb && !e_hb_busy;
        con_acc  = i_con_tx_stb && !e_con_busy;
        pre_stb  = o_tx_stb;
        pre_byte = o_tx_byte;
        pre_busy = i_tx_busy;
        @(posedge i_clk);
        if (i_reset) begin
            m_lock = 0; m_idle = 0; m_ptr_con = 0;
            m_tx_stb = 0; m_tx_byte = '0;
            m_hb_rx = 0; m_con_rx = 0; m_rx_data = '0;
        end else begin
            if (pre_stb && !pre_busy) sent_q.push_back(pre_byte);
            m_con_rx = i_rx_stb && i_rx_byte[7];
            m_hb_rx  = i_rx_stb && !i_rx_byte[7];
            if (i_rx_stb) m_rx_data = i_rx_byte[6:0];
            if (can_load) begin
                if (hb_acc) begin
                    m_tx_stb = 1; m_tx_byte = {1'b0, hb_d};
                end else if (con_acc) begin
                    m_tx_stb = 1; m_tx_byte = {1'b1, con_d};
                end else begin
                    m_tx_stb = 0;
                end
            end
            if (!m_lock) begin
                if (hb_acc) begin
                    m_ptr_con = 1;
                    m_lock    = (hb_d != 7'h0a);
                    m_idle    = 0;
                end else if (con_acc) begin
                    m_ptr_con = 0;
                end
            end else if (hb_acc) begin
                m_idle = 0;
                if (hb_d == 7'h0a) begin
                    m_lock = 0; m_ptr_con = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_lock = 0; m_idle = 0; m_ptr_con = 1;
                end
            end
            if (hb_acc)  void'(hb_q.pop_front());
            if (con_acc) void'(con_q.pop_front());
        end
        #1;
        chk("tx_stb",      32'(o_tx_stb),      32'(m_tx_stb));
        chk("tx_byte",     32'(o_tx_byte),     32'(m_tx_byte));
        chk("hb_rx_stb",   32'(o_hb_rx_stb),   32'(m_hb_rx));
        chk("con_rx_stb",  32'(o_con_rx_stb),  32'(m_con_rx));
        chk("hb_rx_data",  32'(o_hb_rx_data),  32'(m_rx_data));
        chk("con_rx_data", 32'(o_con_rx_data), 32'(m_rx_data));
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_sent(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, 32'(sent_q.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < sent_q.size(); k++)
            chk(tag, 32'(sent_q[k]), 32'(exp[k]));
    endtask

    initial begin
        int n;
        logic [7:0] exp[$];

        i_reset = 1'b1; i_rx_stb = 1'b0; i_rx_byte = '0; i_tx_busy = 1'b0;
        i_hb_tx_stb = 1'b0; i_hb_tx_data = '0; i_con_tx_stb = 1'b0; i_con_tx_data = '0;
        @(negedge i_clk);
        run(2);
        i_reset = 1'b0;
        chk("reset_tx_stb",  32'(o_tx_stb),     32'(0));
        chk("reset_tx_byte", 32'(o_tx_byte),    32'(0));
        chk("reset_rx_stbs", 32'({o_hb_rx_stb, o_con_rx_stb}), 32'(0));
        chk("reset_rx_data", 32'({o_hb_rx_data, o_con_rx_data}), 32'(0));

        // RX demux
        i_rx_stb = 1'b1; i_rx_byte = 8'hC1; step();
        chk("rx_con_first", 32'({o_con_rx_stb, o_hb_rx_stb, o_con_rx_data}), 32'({2'b10, 7'h41}));
        i_rx_byte = 8'h41; step();
        chk("rx_hb_second", 32'({o_con_rx_stb, o_hb_rx_stb, o_hb_rx_data}), 32'({2'b01, 7'h41}));
        i_rx_stb = 1'b0; step();
        chk("rx_quiet", 32'({o_con_rx_stb, o_hb_rx_stb}), 32'(0));

        // console only, back to back
        sent_q.delete();
        con_q = '{7'h41, 7'h42};
        step(); chk("con_first",  32'(o_tx_byte), 32'(8'hC1));
        step(); chk("con_second", 32'(o_tx_byte), 32'(8'hC2));
        run(2);
        exp = '{8'hC1, 8'hC2};
        chk_sent("con_seq", exp);

        // packet atomicity against a waiting console character
        sent_q.delete();
        hb_q  = '{7'h52, 7'h31, 7'h32, 7'h33, 7'h34, 7'h0a};
        con_q = '{7'h78};
        run(10);
        exp = '{8'h52, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0a, 8'hF8};
        chk_sent("packet_seq", exp);

        // round robin between newline-only hexbus and console
        sent_q.delete();
        hb_q  = '{7'h0a, 7'h0a, 7'h0a};
        con_q = '{7'h61, 7'h62, 7'h63};
        run(8);
        exp = '{8'h0a, 8'hE1, 8'h0a, 8'hE2, 8'h0a, 8'hE3};
        chk_sent("rr_seq", exp);

        // lock timeout
        sent_q.delete();
        hb_q  = '{7'h52};
        con_q = '{7'h79};
        n = 0;
        while (con_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TMO + 2));
        run(2);
        exp = '{8'h52, 8'hF9};
        chk_sent("timeout_seq", exp);

        // backpressure, then reset while locked with a byte pending
        i_tx_busy = 1'b1;
        con_q = '{7'h7a};
        step();
        hb_q = '{7'h51};
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_byte_stable", 32'({o_tx_stb, o_tx_byte}), 32'({1'b1, 8'hFA}));
            chk("bp_both_busy",   32'({o_hb_tx_busy, o_con_tx_busy}), 32'(2'b11));
        end
        i_tx_busy = 1'b0;
        step();
        sent_q.delete();
        i_tx_busy = 1'b1;
        run(2);
        i_reset = 1'b1; step(); i_reset = 1'b0;
        chk("reset_drop_stb", 32'(o_tx_stb), 32'(0));
        i_tx_busy = 1'b0;
        con_q = '{7'h6b};
        run(3);
        exp = '{8'hEB};
        chk_sent("after_reset_seq", exp);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_tx_busy = ($urandom_range(0, 3) == 0);
            i_rx_stb  = 1'($urandom_range(0, 1));
            i_rx_byte = 8'($urandom);
            if (hb_q.size() == 0 && $urandom_range(0, 5) == 0) begin
                int len = $urandom_range(1, 5);
                for (int k = 0; k < len; k++)
                    hb_q.push_back(($urandom_range(0, 2) == 0) ? 7'h0a : 7'($urandom_range(32, 126)));
            end
            if (con_q.size() == 0 && $urandom_range(0, 3) == 0)
                con_q.push_back(7'($urandom_range(32, 126)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
